// File: rtl/arith_seq_unit_if.sv
// arith_seq_unit_if -- request/response bundle for the arith_seq_unit coprocessor.
//
// The core side (master) drives the operands and the start request. The
// arithmetic unit (slave) returns its status and the registered result.
//
//   start   request; a rising edge launches one operation
//   mode    0 = divide, 1 = square root
//   a       dividend / sqrt operand (AW bits)
//   b       divisor (BW bits), ignored for sqrt
//   fbits   fraction bits for divide (FBW bits), clamped to MAXF
//   busy    operation in progress
//   done    one-cycle pulse when result/sat/err are valid
//   result  rounded result (QW bits), held until the next done
//   sat     result saturated to all ones, held
//   err     divide-by-zero or unsupported mode, held
interface arith_seq_unit_if #(
   parameter int AW   = 16,
   parameter int BW   = 16,
   parameter int QW   = 24,
   parameter int MAXF = 15
);
   localparam int FBW = $clog2(MAXF + 1);

   logic           start;
   logic           mode;
   logic [AW-1:0]  a;
   logic [BW-1:0]  b;
   logic [FBW-1:0] fbits;
   logic           busy;
   logic           done;
   logic [QW-1:0]  result;
   logic           sat;
   logic           err;

   modport master (
      output start, mode, a, b, fbits,
      input  busy, done, result, sat, err
   );

   modport slave (
      input  start, mode, a, b, fbits,
      output busy, done, result, sat, err
   );
endinterface

// File: rtl/arith_seq_unit.sv
// arith_seq_unit -- multi-cycle fixed-point divide / reciprocal / square root.
//
// Rounded division a*2^fbits/b (reciprocal when a=1) using a restoring
// divider with a fixed latency of AW+MAXF+1 iterations, and optionally a
// rounded integer square root (AW/2 iterations). Results round half-LSB
// upward and saturate to all ones on overflow or divide-by-zero.
//
// Optional feature macro: ARITH_SQRT_EN
//   defined   : mode=1 computes the rounded square root of a
//   undefined : sqrt datapath is absent; mode=1 completes like a
//               divide-by-zero (all ones, sat=1, err=1) one cycle later
//
// Ports:
//   CLK    system clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    arith_seq_unit_if.slave (start/mode/a/b/fbits in,
//          busy/done/result/sat/err out, all outputs registered)
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for a rising edge on start
// DIV    | restoring divide, one quotient bit per cycle
// SQRT   | digit-by-digit root, one root bit per cycle
// FINISH | round, saturate, write outputs, pulse done
module arith_seq_unit #(
   parameter int AW   = 16,
   parameter int BW   = 16,
   parameter int QW   = 24,
   parameter int MAXF = 15
) (
   input  logic            CLK,
   input  logic            reset,
   arith_seq_unit_if.slave bus
);
   localparam int FBW = $clog2(MAXF + 1);
   localparam int NW  = AW + MAXF + 1;
   localparam int HW  = AW / 2;
   localparam int MW  = ((NW > QW) ? NW : QW) + 1;
   localparam int CW  = $clog2(NW);
   localparam logic [MW-1:0] QMAX = (MW'(1) << QW) - MW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIV    = 2'd1,
      SQRT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t         state;
   logic           start_q;
   logic           busy_r;
   logic           done_r;
   logic [QW-1:0]  result_r;
   logic           sat_r;
   logic           err_r;
   logic           fail_q;
   logic [CW-1:0]  cnt;
   logic [BW-1:0]  b_q;
   logic [NW-1:0]  nq;
   logic [BW-1:0]  div_rem;

   logic [FBW-1:0] fb_clamp;
   logic [NW-1:0]  num_launch;
   logic [BW:0]    div_trial;
   logic [BW:0]    div_next;
   logic           div_ge;
   logic [MW-1:0]  div_round;
   logic           div_unused;

   // nq starts as the shifted numerator; each iteration shifts its MSB into
   // the partial remainder and the new quotient bit into its LSB, so after
   // NW iterations it holds the full quotient.
   always_comb begin
      fb_clamp   = (bus.fbits > FBW'(MAXF)) ? FBW'(MAXF) : bus.fbits;
      num_launch = NW'(bus.a) << (int'(fb_clamp) + 1);
      div_trial  = {div_rem, nq[NW-1]};
      div_ge     = (div_trial >= {1'b0, b_q});
      div_next   = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
      // quotient carries one extra fraction bit; adding it back rounds half up
      div_round  = MW'(nq >> 1) + MW'(nq[0]);
   end

   // remainder after a restoring step is always below b, so its MSB is zero
   assign div_unused = div_next[BW];

`ifdef ARITH_SQRT_EN
   localparam int SRW = HW + 2;
   localparam int STW = HW + 4;

   logic           mode_q;
   logic [AW-1:0]  sq_x;
   logic [HW-1:0]  sq_s;
   logic [SRW-1:0] sq_rem;
   logic [STW-1:0] sq_trial;
   logic [STW-1:0] sq_sub;
   logic [STW-1:0] sq_next;
   logic           sq_ge;
   logic           sq_round;
   logic [1:0]     sq_unused;

   always_comb begin
      sq_trial = {sq_rem, sq_x[AW-1 -: 2]};
      sq_sub   = STW'({sq_s, 2'b01});
      sq_ge    = (sq_trial >= sq_sub);
      sq_next  = sq_ge ? (sq_trial - sq_sub) : sq_trial;
      // sqrt(a) >= s + 1/2  <=>  a - s^2 > s for integers; an all-ones root
      // would wrap, so it is left unrounded
      sq_round = (sq_rem > SRW'(sq_s)) && (sq_s != '1);
   end

   // remainder never exceeds 2*s, so the top two trial bits are zero
   assign sq_unused = sq_next[STW-1:SRW];
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         sat_r    <= 1'b0;
         err_r    <= 1'b0;
         fail_q   <= 1'b0;
         cnt      <= '0;
         b_q      <= '0;
         nq       <= '0;
         div_rem  <= '0;
`ifdef ARITH_SQRT_EN
         mode_q   <= 1'b0;
         sq_x     <= '0;
         sq_s     <= '0;
         sq_rem   <= '0;
`endif
      end else begin
         start_q <= bus.start;
         done_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !start_q) begin
                  busy_r  <= 1'b1;
                  b_q     <= bus.b;
                  nq      <= num_launch;
                  div_rem <= '0;
`ifdef ARITH_SQRT_EN
                  mode_q  <= bus.mode;
                  sq_x    <= bus.a;
                  sq_s    <= '0;
                  sq_rem  <= '0;
`endif
                  if (bus.mode) begin
`ifdef ARITH_SQRT_EN
                     fail_q <= 1'b0;
                     cnt    <= CW'(HW - 1);
                     state  <= SQRT;
`else
                     fail_q <= 1'b1;
                     state  <= FINISH;
`endif
                  end else if (bus.b == '0) begin
                     fail_q <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     fail_q <= 1'b0;
                     cnt    <= CW'(NW - 1);
                     state  <= DIV;
                  end
               end
            end
            DIV: begin
               nq      <= {nq[NW-2:0], div_ge};
               div_rem <= div_next[BW-1:0];
               if (cnt == '0) state <= FINISH;
               else           cnt   <= cnt - CW'(1);
            end
`ifdef ARITH_SQRT_EN
            SQRT: begin
               sq_x   <= {sq_x[AW-3:0], 2'b00};
               sq_s   <= {sq_s[HW-2:0], sq_ge};
               sq_rem <= sq_next[SRW-1:0];
               if (cnt == '0) state <= FINISH;
               else           cnt   <= cnt - CW'(1);
            end
`endif
            FINISH: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               if (fail_q) begin
                  result_r <= '1;
                  sat_r    <= 1'b1;
                  err_r    <= 1'b1;
`ifdef ARITH_SQRT_EN
               end else if (mode_q) begin
                  result_r <= QW'(sq_s + HW'(sq_round));
                  sat_r    <= 1'b0;
                  err_r    <= 1'b0;
`endif
               end else if (div_round > QMAX) begin
                  result_r <= '1;
                  sat_r    <= 1'b1;
                  err_r    <= 1'b0;
               end else begin
                  result_r <= div_round[QW-1:0];
                  sat_r    <= 1'b0;
                  err_r    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.sat    = sat_r;
   assign bus.err    = err_r;
endmodule
